regfile_access_ctrl: RTL

Initiator for the register-file load/store port (`ld_str`, `register_addr`, `store_val`, `load_val`). It accepts load/store requests from the pipeline over a valid/ready handshake and buffers them in a small FIFO. It sequences each request onto the register-file port, waits the read latency for loads, and returns one response per request. It sits between decode/writeback and the register file, so no upstream stage drives the raw port directly.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/req_fifo.sv | 61 ++++++
 rtl/regfile_access_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file access controller: default widths,
// op encoding, the architectural zero register and the FSM state encoding.
package regfile_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    // Same encoding as the register-file ld_str pin.
    localparam logic OP_STORE = 1'b0;
    localparam logic OP_LOAD  = 1'b1;

    // x0 reads as zero and ignores writes.
    localparam int ZERO_REG = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/req_fifo.sv
// Small synchronous request FIFO. Power-of-two depth, pointers wrap naturally,
// occupancy counter gives full/empty directly from registers.
module req_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: buffers pipeline load/store requests,
// issues them one at a time on the register-file port and returns one
// response per request, in order.
//
// Handshakes: a transfer occurs on the rising clock edge where valid && ready
// are both high; the valid side holds its payload stable until that edge.
module regfile_access_ctrl
    import regfile_pkg::*;
#(
    parameter int DATA_W     = RF_DATA_W,
    parameter int ADDR_W     = RF_ADDR_W,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_ld_str,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_is_load,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rf_ld_str,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_store_val,
    input  logic [DATA_W-1:0] rf_load_val,
    output state_e            dbg_state
);

    localparam int REQ_W = 1 + ADDR_W + DATA_W;
    localparam int LAT_W = $clog2(RD_LAT) + 1;

    logic [REQ_W-1:0]  fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              head_ld;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;

    state_e            state_q;
    logic              hold_ld_q;
    logic              hold_x0_q;
    logic [LAT_W-1:0]  lat_cnt_q;
    logic              rsp_valid_q;
    logic              rsp_is_load_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rf_ld_str_q;
    logic [ADDR_W-1:0] rf_addr_q;
    logic [DATA_W-1:0] rf_store_val_q;

    // Ready comes from the registered full flag, so a pop never frees a slot
    // in the same cycle.
    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && req_ready;
    // The head leaves the FIFO whenever the FSM is free to take new work.
    assign fifo_pop  = !fifo_empty &&
                       ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready));
    assign {head_ld, head_addr, head_wdata} = fifo_head;

    req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk         (clk),
        .rst         (reset),
        .push_i      (fifo_push),
        .push_data_i ({req_ld_str, req_addr, req_wdata}),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Request sequencer: pop, issue, wait read latency, hold the response.
    // x0 requests still spend the issue slot, but with the port left idle, so
    // every non-load request answers with the same latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            hold_ld_q      <= OP_LOAD;
            hold_x0_q      <= 1'b1;
            lat_cnt_q      <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_is_load_q  <= 1'b0;
            rsp_data_q     <= '0;
            rf_ld_str_q    <= OP_LOAD;
            rf_addr_q      <= '0;
            rf_store_val_q <= '0;
        end else begin
            case (state_q)
                ST_ISSUE: begin
                    if ((hold_ld_q == OP_LOAD) && !hold_x0_q) begin
                        state_q   <= ST_WAIT;
                        lat_cnt_q <= LAT_W'(RD_LAT - 1);
                    end else begin
                        state_q        <= ST_RESP;
                        rsp_valid_q    <= 1'b1;
                        rsp_is_load_q  <= hold_ld_q;
                        rsp_data_q     <= '0;
                        rf_ld_str_q    <= OP_LOAD;
                        rf_addr_q      <= '0;
                        rf_store_val_q <= '0;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt_q == '0) begin
                        state_q       <= ST_RESP;
                        rsp_valid_q   <= 1'b1;
                        rsp_is_load_q <= 1'b1;
                        rsp_data_q    <= rf_load_val;
                        rf_ld_str_q   <= OP_LOAD;
                        rf_addr_q     <= '0;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q       <= ST_IDLE;
                        rsp_valid_q   <= 1'b0;
                        rsp_is_load_q <= 1'b0;
                        rsp_data_q    <= '0;
                    end
                end
                default: begin
                end
            endcase
            // Taking the head overrides the IDLE/RESP outcome above.
            if (fifo_pop) begin
                state_q   <= ST_ISSUE;
                hold_ld_q <= head_ld;
                hold_x0_q <= (head_addr == ADDR_W'(ZERO_REG));
                if (head_addr != ADDR_W'(ZERO_REG)) begin
                    rf_ld_str_q    <= head_ld;
                    rf_addr_q      <= head_addr;
                    rf_store_val_q <= (head_ld == OP_STORE) ? head_wdata : '0;
                end
            end
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_is_load  = rsp_is_load_q;
    assign rsp_data     = rsp_data_q;
    assign rf_ld_str    = rf_ld_str_q;
    assign rf_addr      = rf_addr_q;
    assign rf_store_val = rf_store_val_q;
    assign dbg_state    = state_q;

endmodule
